// File: rtl/bidir_pad_conditioner.sv
// Multi-channel bidirectional / open-drain pad conditioner: registered drive, synchronised and
// glitch-filtered readback, optional contention flags (macro BIDIR_PAD_CONTENTION_DETECT_EN).
module bidir_pad_conditioner #(
    parameter int                NUM_CH            = 4,
    parameter int                SYNC_STAGES       = 2,
    parameter int                FILTER_CYCLES     = 4,
    parameter logic [NUM_CH-1:0] OD_MASK           = {NUM_CH{1'b1}},
    parameter int                CONTENTION_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] out_value,
    input  logic [NUM_CH-1:0] out_enable,
    input  logic [NUM_CH-1:0] pad_i,
    output logic [NUM_CH-1:0] pad_o,
    output logic [NUM_CH-1:0] pad_oe,
    output logic [NUM_CH-1:0] in_value,
    output logic [NUM_CH-1:0] in_changed,
    output logic [NUM_CH-1:0] contention,
    input  logic              contention_clear
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int CW = $clog2(CONTENTION_CYCLES + 1);

    logic [NUM_CH-1:0] pad_o_q, pad_o_d;
    logic [NUM_CH-1:0] pad_oe_q, pad_oe_d;

    // Open-drain channels never drive high: a 1 simply releases the pad.
    always_comb begin
        pad_oe_d = (OD_MASK & ~out_value) | (~OD_MASK & out_enable);
        pad_o_d  = ~OD_MASK & out_value;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pad_o_q  <= '0;
            pad_oe_q <= '0;
        end else begin
            pad_o_q  <= pad_o_d;
            pad_oe_q <= pad_oe_d;
        end
    end

    assign pad_o  = pad_o_q;
    assign pad_oe = pad_oe_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
        logic                   in_value_q, in_value_d;
        logic                   in_changed_q, in_changed_d;

        always_comb begin
            sync_d       = {sync_q[SYNC_STAGES-2:0], pad_i[ch]};
            filt_cnt_d   = filt_cnt_q;
            in_value_d   = in_value_q;
            in_changed_d = 1'b0;
            if (sync_q[SYNC_STAGES-1] == in_value_q) begin
                filt_cnt_d = '0;
            end else if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
                in_value_d   = ~in_value_q;
                in_changed_d = 1'b1;
                filt_cnt_d   = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end

        // Idle bus is pulled up, so everything on the input side resets high.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sync_q       <= '1;
                filt_cnt_q   <= '1;
                in_value_q   <= 1'b1;
                in_changed_q <= 1'b0;
            end else begin
                sync_q       <= sync_d;
                filt_cnt_q   <= filt_cnt_d;
                in_value_q   <= in_value_d;
                in_changed_q <= in_changed_d;
            end
        end

        assign in_value[ch]   = in_value_q;
        assign in_changed[ch] = in_changed_q;

`ifdef BIDIR_PAD_CONTENTION_DETECT_EN
        logic [CW-1:0] cont_cnt_q, cont_cnt_d;
        logic          cont_q, cont_d;
        logic          mismatch;

        // A released open-drain line held low has pad_oe=0, so clock stretching is never flagged.
        assign mismatch = pad_oe_q[ch] & (in_value_q != pad_o_q[ch]);

        always_comb begin
            cont_cnt_d = cont_cnt_q;
            cont_d     = cont_q;
            if (contention_clear) begin
                cont_cnt_d = '0;
                cont_d     = 1'b0;
            end else if (!mismatch) begin
                cont_cnt_d = '0;
            end else begin
                if (cont_cnt_q == CW'(CONTENTION_CYCLES - 1))
                    cont_d = 1'b1;
                if (cont_cnt_q != CW'(CONTENTION_CYCLES))
                    cont_cnt_d = cont_cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                cont_cnt_q <= '0;
                cont_q     <= 1'b0;
            end else begin
                cont_cnt_q <= cont_cnt_d;
                cont_q     <= cont_d;
            end
        end

        assign contention[ch] = cont_q;
`else
        assign contention[ch] = 1'b0;
`endif
    end

`ifndef BIDIR_PAD_CONTENTION_DETECT_EN
    logic unused_contention_clear;
    assign unused_contention_clear = contention_clear;
`endif

endmodule

// File: tb/tb_bidir_pad_conditioner.sv
// Directed scoreboard bench for bidir_pad_conditioner (NUM_CH=4, OD_MASK=4'b0111).
module tb_bidir_pad_conditioner;

    localparam int S_PO = 0, S_POE = 1, S_IV = 2, S_IC = 3, S_CT = 4;
`ifdef BIDIR_PAD_CONTENTION_DETECT_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] out_value, out_enable, pad_i, pad_o, pad_oe;
    logic [3:0] in_value, in_changed, contention;
    logic       contention_clear;
    logic [3:0] force_en, force_val;

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] mask;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;

    always #5 clk = ~clk;

    // Board model: forced level where the bench overrides, else driven value or pull-up.
    assign pad_i = (force_en & force_val) | (~force_en & ((pad_oe & pad_o) | ~pad_oe));

    bidir_pad_conditioner #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4),
        .OD_MASK(4'b0111), .CONTENTION_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .out_value(out_value), .out_enable(out_enable), .pad_i(pad_i),
        .pad_o(pad_o), .pad_oe(pad_oe),
        .in_value(in_value), .in_changed(in_changed),
        .contention(contention), .contention_clear(contention_clear)
    );

    function automatic logic [3:0] observe(int sel);
        case (sel)
            S_PO:    return pad_o;
            S_POE:   return pad_oe;
            S_IV:    return in_value;
            S_IC:    return in_changed;
            default: return contention;
        endcase
    endfunction

    task automatic expect_val(string tag, int sel, logic [3:0] mask, logic [3:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.mask = mask; e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t       e;
        logic [3:0] obs;
        @(posedge clk);
        #1;
        edge_n++;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel) & e.mask;
            n_cmp++;
            assert (obs === (e.val & e.mask)) else begin
                n_bad++;
                $error("FAIL %s @edge %0d: observed %b expected %b", e.tag, edge_n, obs, e.val & e.mask);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; out_value = 4'b0000; out_enable = 4'b0000;
        contention_clear = 1'b0; force_en = 4'b0000; force_val = 4'b0000;

        // Reset held for 3 cycles
        repeat (3) begin
            expect_val("rst_pad_oe", S_POE, 4'hF, 4'h0);
            expect_val("rst_pad_o", S_PO, 4'hF, 4'h0);
            expect_val("rst_in_value", S_IV, 4'hF, 4'hF);
            expect_val("rst_in_changed", S_IC, 4'hF, 4'h0);
            expect_val("rst_contention", S_CT, 4'hF, 4'h0);
            tick();
        end

        reset_n = 1'b1; out_value = 4'b0111;
        expect_val("idle_pad_oe", S_POE, 4'hF, 4'h0);
        tick();
        repeat (3) tick();

        // Open-drain drive low on ch0, pad follows, loopback after 1+2+4 edges
        out_value[0] = 1'b0;
        expect_val("od_pad_oe0", S_POE, 4'h1, 4'h1);
        expect_val("od_pad_o0", S_PO, 4'h1, 4'h0);
        tick();
        for (int i = 2; i <= 8; i++) begin
            expect_val("loop_in_value0", S_IV, 4'h1, (i >= 7) ? 4'h0 : 4'h1);
            expect_val("loop_in_changed0", S_IC, 4'h1, (i == 7) ? 4'h1 : 4'h0);
            tick();
        end
        out_value[0] = 1'b1;
        repeat (7) tick();
        expect_val("release_in_value0", S_IV, 4'h1, 4'h1);
        expect_val("release_pad_oe0", S_POE, 4'h1, 4'h0);
        tick();

        // Glitch of 3 cycles on ch1 is rejected
        force_en[1] = 1'b1; force_val[1] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            expect_val("glitch3_in_value1", S_IV, 4'h2, 4'h2);
            expect_val("glitch3_in_changed1", S_IC, 4'h2, 4'h0);
            tick();
            if (i == 3) force_en[1] = 1'b0;
        end

        // A 4-cycle low pulse passes and lasts exactly 4 cycles
        force_en[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            expect_val("pulse4_in_value1", S_IV, 4'h2, (i >= 6 && i <= 9) ? 4'h0 : 4'h2);
            expect_val("pulse4_in_changed1", S_IC, 4'h2, (i == 6 || i == 10) ? 4'h2 : 4'h0);
            tick();
            if (i == 4) force_en[1] = 1'b0;
        end

        // Tristate ch3
        out_enable[3] = 1'b1; out_value[3] = 1'b1;
        expect_val("ts_en_pad_oe3", S_POE, 4'h8, 4'h8);
        expect_val("ts_en_pad_o3", S_PO, 4'h8, 4'h8);
        expect_val("od_pad_o_low", S_PO, 4'h7, 4'h0);
        tick();
        out_enable[3] = 1'b0;
        expect_val("ts_dis_pad_oe3", S_POE, 4'h8, 4'h0);
        expect_val("ts_dis_pad_o3", S_PO, 4'h8, 4'h8);
        tick();
        out_value[3] = 1'b0;
        expect_val("ts_dis0_pad_oe3", S_POE, 4'h8, 4'h0);
        expect_val("ts_dis0_pad_o3", S_PO, 4'h8, 4'h0);
        tick();

        // Contention on ch2: driven low, pad stuck high
        force_en[2] = 1'b1; force_val[2] = 1'b1;
        out_value[2] = 1'b0;
        expect_val("ct_pad_oe2", S_POE, 4'h4, 4'h4);
        expect_val("ct_pad_o2", S_PO, 4'h4, 4'h0);
        expect_val("ct_in_value2", S_IV, 4'h4, 4'h4);
        expect_val("ct_start", S_CT, 4'hF, 4'h0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            expect_val("ct_detect", S_CT, 4'h4, (k == 16 && CD_EN) ? 4'h4 : 4'h0);
            tick();
        end
        repeat (3) begin
            expect_val("ct_sticky", S_CT, 4'h4, CD_EN ? 4'h4 : 4'h0);
            expect_val("ct_in_value2_hold", S_IV, 4'h4, 4'h4);
            tick();
        end
        contention_clear = 1'b1;
        expect_val("ct_clear", S_CT, 4'hF, 4'h0);
        tick();
        contention_clear = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            expect_val("ct_after_clear", S_CT, 4'h4, 4'h0);
            tick();
        end
        contention_clear = 1'b1;
        expect_val("ct_clear_wins", S_CT, 4'hF, 4'h0);
        tick();
        contention_clear = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            expect_val("ct_redetect", S_CT, 4'h4, (k == 16 && CD_EN) ? 4'h4 : 4'h0);
            tick();
        end

        // Reset mid-operation releases pads and discards state
        reset_n = 1'b0;
        expect_val("mid_rst_pad_oe", S_POE, 4'hF, 4'h0);
        expect_val("mid_rst_pad_o", S_PO, 4'hF, 4'h0);
        expect_val("mid_rst_contention", S_CT, 4'hF, 4'h0);
        expect_val("mid_rst_in_value", S_IV, 4'hF, 4'hF);
        expect_val("mid_rst_in_changed", S_IC, 4'hF, 4'h0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
